// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: machine width, canonical NOP and the
// fetch-stage state encoding.
package rv32_pkg;

  localparam int XLEN = 32;

  // add x0, x0, x0 -- the bubble inserted whenever IF/ID holds no real work
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  // Raw encodings kept alongside the enum for code that wants plain vectors
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef enum logic [0:0] {
    RUN  = ST_RUN,
    HALT = ST_HALT
  } fetch_state_e;

  // A byte address is a legal instruction target only if word aligned
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid bit, byte PC and instruction word.
// Flush wins over hold; a flushed slot carries a NOP with valid cleared and
// keeps its old PC (the PC of an invalid slot is meaningless downstream).
module if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold_i,
  input  logic         flush_i,
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] instr_i,
  output logic         valid_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] instr_o
);
  import rv32_pkg::*;

  logic         valid_q, valid_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] instr_q, instr_d;

  // Next-state selection: flush, then hold, then load the fetched word
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = W'(NOP_INSTR);
    end else if (!hold_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  // Register with asynchronous clear to an empty NOP slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= W'(NOP_INSTR);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage_fetch.sv
// RV32I instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and feeds the IF/ID register. A misaligned redirect
// target parks the stage in HALT until reset.
module if_stage_fetch #(
  parameter int              XLEN     = 32,
  parameter int              IMEM_AW  = 6,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [XLEN-1:0]    imem_data_i,
  output logic               ifid_valid_o,
  output logic [XLEN-1:0]    ifid_pc_o,
  output logic [XLEN-1:0]    ifid_instr_o,
  output logic               misalign_o
);
  import rv32_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush;

  // Next PC, fetch state and IF/ID flush; redirect outranks stall
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect_i) begin
          flush = 1'b1;
          if (is_aligned(redirect_pc_i[1:0])) begin
            pc_d = redirect_pc_i;
          end else begin
            state_d = HALT;
          end
        end else if (!stall_i) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      HALT: begin
        // PC frozen; keep pumping bubbles into decode
        flush = 1'b1;
      end
      default: begin
        state_d = HALT;
        flush   = 1'b1;
      end
    endcase
  end

  // PC and fetch state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Word address; upper PC bits are dropped so fetch wraps around memory
  assign imem_addr_o = pc_q[IMEM_AW+1:2];
  assign misalign_o  = (state_q == HALT);

  if_id_reg #(
    .W (XLEN)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (stall_i),
    .flush_i (flush),
    .pc_i    (pc_q),
    .instr_i (imem_data_i),
    .valid_o (ifid_valid_o),
    .pc_o    (ifid_pc_o),
    .instr_o (ifid_instr_o)
  );

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: table of per-cycle stimulus with expected
// outputs, pushed to a scoreboard queue when driven and popped after the
// edge, plus a hand-written mid-operation reset sequence.
module tb_if_stage_fetch;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        misalign;

  logic [31:0] imem [64];

  int errors = 0;
  int checks = 0;

  if_stage_fetch #(
    .XLEN     (32),
    .IMEM_AW  (6),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .ifid_valid_o  (ifid_valid),
    .ifid_pc_o     (ifid_pc),
    .ifid_instr_o  (ifid_instr),
    .misalign_o    (misalign)
  );

  assign imem_data = imem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [5:0]  addr;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  localparam int NVEC = 18;
  vec_t vec [NVEC];
  exp_t sb [$];

  function automatic vec_t mk(logic s, logic r, logic [31:0] t, logic [5:0] a,
                              logic v, logic [31:0] p, logic m);
    vec_t x;
    x.stall = s; x.redir = r; x.tgt = t; x.addr = a;
    x.valid = v; x.pc = p; x.mis = m;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  exp_t e;
  logic [5:0] widx;

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + i * 32'h0001_0101;

    //           stall redir target       addr valid pc           mis
    vec[0]  = mk(0, 0, 32'h0,        6'd1,  1, 32'h0,   0);  // first valid fetch
    vec[1]  = mk(0, 0, 32'h0,        6'd2,  1, 32'h4,   0);
    vec[2]  = mk(0, 0, 32'h0,        6'd3,  1, 32'h8,   0);
    vec[3]  = mk(1, 0, 32'h0,        6'd3,  1, 32'h8,   0);  // stall holds
    vec[4]  = mk(1, 0, 32'h0,        6'd3,  1, 32'h8,   0);
    vec[5]  = mk(0, 0, 32'h0,        6'd4,  1, 32'hC,   0);  // resume
    vec[6]  = mk(0, 1, 32'h44,       6'd17, 0, 32'h0,   0);  // redirect flush
    vec[7]  = mk(0, 0, 32'h0,        6'd18, 1, 32'h44,  0);
    vec[8]  = mk(1, 1, 32'h20,       6'd8,  0, 32'h0,   0);  // redirect beats stall
    vec[9]  = mk(0, 0, 32'h0,        6'd9,  1, 32'h20,  0);
    vec[10] = mk(0, 1, 32'hF8,       6'd62, 0, 32'h0,   0);
    vec[11] = mk(0, 0, 32'h0,        6'd63, 1, 32'hF8,  0);
    vec[12] = mk(0, 0, 32'h0,        6'd0,  1, 32'hFC,  0);  // address wraps
    vec[13] = mk(0, 0, 32'h0,        6'd1,  1, 32'h100, 0);  // carries word 0
    vec[14] = mk(0, 1, 32'h46,       6'd1,  0, 32'h0,   1);  // misaligned
    vec[15] = mk(0, 0, 32'h0,        6'd1,  0, 32'h0,   1);  // halted
    vec[16] = mk(0, 1, 32'h10,       6'd1,  0, 32'h0,   1);  // redirect ignored
    vec[17] = mk(1, 0, 32'h0,        6'd1,  0, 32'h0,   1);

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_addr",    {26'b0, imem_addr}, 32'h0);
    chk("reset_valid",   {31'b0, ifid_valid}, 32'h0);
    chk("reset_pc",      ifid_pc, 32'h0);
    chk("reset_instr",   ifid_instr, NOP);
    chk("reset_misalign",{31'b0, misalign}, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      stall = vec[i].stall; redirect = vec[i].redir; redirect_pc = vec[i].tgt;
      e.addr  = vec[i].addr;
      e.valid = vec[i].valid;
      e.pc    = vec[i].pc;
      widx    = vec[i].pc[7:2];
      e.instr = vec[i].valid ? imem[widx] : NOP;
      e.mis   = vec[i].mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL scoreboard_empty: got 0 entries required 1");
      end else begin
        e = sb.pop_front();
        $display("vec %0d: addr=%0d valid=%0b pc=%h instr=%h misalign=%0b",
                 i, imem_addr, ifid_valid, ifid_pc, ifid_instr, misalign);
        chk($sformatf("v%0d_addr", i),  {26'b0, imem_addr}, {26'b0, e.addr});
        chk($sformatf("v%0d_valid", i), {31'b0, ifid_valid}, {31'b0, e.valid});
        chk($sformatf("v%0d_instr", i), ifid_instr, e.instr);
        chk($sformatf("v%0d_mis", i),   {31'b0, misalign}, {31'b0, e.mis});
        if (e.valid) chk($sformatf("v%0d_pc", i), ifid_pc, e.pc);
      end
      @(negedge clk);
    end

    // Reset asserted mid-cycle while halted, with stall and a misaligned
    // redirect pending: state must clear at once and stay clear
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h46;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: addr=%0d valid=%0b misalign=%0b", imem_addr, ifid_valid, misalign);
    chk("arst_addr",     {26'b0, imem_addr}, 32'h0);
    chk("arst_valid",    {31'b0, ifid_valid}, 32'h0);
    chk("arst_pc",       ifid_pc, 32'h0);
    chk("arst_instr",    ifid_instr, NOP);
    chk("arst_misalign", {31'b0, misalign}, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_mis",  {31'b0, misalign}, 32'h0);
    chk("arst_hold_addr", {26'b0, imem_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("release_valid", {31'b0, ifid_valid}, 32'h0);
    @(posedge clk);
    #1;
    $display("post reset: addr=%0d valid=%0b pc=%h instr=%h", imem_addr, ifid_valid, ifid_pc, ifid_instr);
    chk("restart_valid", {31'b0, ifid_valid}, 32'h1);
    chk("restart_pc",    ifid_pc, 32'h0);
    chk("restart_instr", ifid_instr, imem[0]);
    chk("restart_addr",  {26'b0, imem_addr}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
